alarm_qual: RTL and testbench

- Qualifies raw rider and platform conditions into the three alarm request signals consumed by the piezo driver: en_steer, too_fast and batt_low.
- Applies abs() and thresholds with hysteresis to wheel speeds and battery voltage.
- Debounces each condition over N consecutive valid samples.
- Converts the steer-enable level into a one-cycle request pulse.
- Sits between the balance/ADC sampling logic and piezo_drv.

---
 rtl/alarm_pkg.sv | 34 +++
 rtl/alarm_deb.sv | 110 +++++++++++
 rtl/alarm_qual.sv | 88 ++++++++
 tb/tb_alarm_qual.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared types, default thresholds and helper functions for the alarm
// qualification block (alarm_qual) and its debouncer (alarm_deb).
// ---------------------------------------------------------------------------
package alarm_pkg;

   // Debouncer state: two stable states plus one pending state for each edge.
   typedef enum logic [1:0] {
      OFF      = 2'd0,
      PEND_ON  = 2'd1,
      ON       = 2'd2,
      PEND_OFF = 2'd3
   } deb_state_t;

   // Default thresholds. Speeds are compared as magnitudes, battery is unsigned.
   localparam logic [11:0] FAST_THR_DEF  = 12'd1536;
   localparam logic [11:0] FAST_HYST_DEF = 12'd128;
   localparam logic [11:0] BATT_THR_DEF  = 12'h800;
   localparam logic [11:0] BATT_HYST_DEF = 12'h040;
   localparam int          DEB_CNT_DEF   = 4;

   // Saturating 12-bit absolute value. -2048 has no positive twin in 12 bits,
   // so it is clamped to 2047 instead of wrapping back to -2048.
   function automatic logic [11:0] abs12_sat(input logic signed [11:0] v);
      if (v == 12'sh800)
         return 12'h7FF;
      else if (v[11])
         return $unsigned(-v);
      else
         return $unsigned(v);
   endfunction

endpackage : alarm_pkg

// File: rtl/alarm_deb.sv
// ---------------------------------------------------------------------------
// alarm_deb
// Hysteresis debouncer. The output sets after DEB_CNT consecutive vld samples
// with hit=1 and clears after DEB_CNT consecutive vld samples with ok=1. A
// vld sample that breaks a pending run returns to the stable state it came
// from and discards the count. Cycles without vld hold state and count.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   vld    in   sample strobe; hit/ok are only considered when high
//   hit    in   sample is in the "set" band
//   ok     in   sample is in the "clear" band
//   out    out  registered debounced level
// ---------------------------------------------------------------------------
module alarm_deb
   import alarm_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEF   // legal range 1..255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vld,
   input  logic hit,
   input  logic ok,
   output logic out
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_CNT);

   deb_state_t state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] cnt_inc;

   assign cnt_inc = cnt + 8'd1;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (vld) begin
         case (state)
            OFF: begin
               if (hit) begin
                  if (DEB_CNT == 1) begin
                     state_nxt = ON;
                  end else begin
                     state_nxt = PEND_ON;
                     cnt_nxt   = 8'd1;
                  end
               end
            end
            PEND_ON: begin
               if (!hit) begin
                  state_nxt = OFF;
                  cnt_nxt   = 8'd0;
               end else if (cnt_inc == DEB_LAST) begin
                  state_nxt = ON;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt   = cnt_inc;
               end
            end
            ON: begin
               if (ok) begin
                  if (DEB_CNT == 1) begin
                     state_nxt = OFF;
                  end else begin
                     state_nxt = PEND_OFF;
                     cnt_nxt   = 8'd1;
                  end
               end
            end
            PEND_OFF: begin
               if (!ok) begin
                  state_nxt = ON;
                  cnt_nxt   = 8'd0;
               end else if (cnt_inc == DEB_LAST) begin
                  state_nxt = OFF;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt   = cnt_inc;
               end
            end
            default: begin
               state_nxt = OFF;
               cnt_nxt   = 8'd0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its inputs from before the edge, independent of statement order.
   // NOTE: all state, including the count, is cleared by the async reset so a
   // pending run never survives a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OFF;
         cnt   <= 8'd0;
         out   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         out   <= (state_nxt == ON) || (state_nxt == PEND_OFF);
      end
   end

endmodule : alarm_deb

// File: rtl/alarm_qual.sv
// ---------------------------------------------------------------------------
// alarm_qual
// Turns raw wheel speeds, battery reading and the steer-enable level into the
// three alarm requests consumed by the piezo driver. Speed and battery are
// compared against hysteresis thresholds and debounced; steer-enable is turned
// into a one-cycle pulse on its rising edge.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   vld          in   new lft_spd/rght_spd/batt are valid this cycle
//   lft_spd      in   [11:0] signed left wheel speed
//   rght_spd     in   [11:0] signed right wheel speed
//   batt         in   [11:0] unsigned battery ADC reading
//   en_steer_in  in   steer-enable level (already synchronous to clk)
//   too_fast     out  debounced overspeed level
//   batt_low     out  debounced low-battery level
//   en_steer     out  one-cycle pulse per rising edge of en_steer_in
// ---------------------------------------------------------------------------
module alarm_qual
   import alarm_pkg::*;
#(
   parameter logic [11:0] FAST_THR  = FAST_THR_DEF,
   parameter logic [11:0] FAST_HYST = FAST_HYST_DEF,
   parameter logic [11:0] BATT_THR  = BATT_THR_DEF,
   parameter logic [11:0] BATT_HYST = BATT_HYST_DEF,
   parameter int          DEB_CNT   = DEB_CNT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld,
   input  logic [11:0] lft_spd,
   input  logic [11:0] rght_spd,
   input  logic [11:0] batt,
   input  logic        en_steer_in,
   output logic        too_fast,
   output logic        batt_low,
   output logic        en_steer
);

   // Clear limits computed in 13 bits so THR-HYST / THR+HYST cannot wrap.
   localparam logic [12:0] FAST_OK_LIM = {1'b0, FAST_THR} - {1'b0, FAST_HYST};
   localparam logic [12:0] BATT_OK_LIM = {1'b0, BATT_THR} + {1'b0, BATT_HYST};

   logic [11:0] lft_abs, rght_abs;
   logic        fast_hit, fast_ok;
   logic        low_hit, low_ok;
   logic        en_steer_d;

   assign lft_abs  = abs12_sat(lft_spd);
   assign rght_abs = abs12_sat(rght_spd);

   assign fast_hit = (lft_abs > FAST_THR) || (rght_abs > FAST_THR);
   assign fast_ok  = ({1'b0, lft_abs} < FAST_OK_LIM) && ({1'b0, rght_abs} < FAST_OK_LIM);

   assign low_hit  = batt < BATT_THR;
   assign low_ok   = {1'b0, batt} > BATT_OK_LIM;

   alarm_deb #(.DEB_CNT(DEB_CNT)) u_fast_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (vld),
      .hit   (fast_hit),
      .ok    (fast_ok),
      .out   (too_fast)
   );

   alarm_deb #(.DEB_CNT(DEB_CNT)) u_batt_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (vld),
      .hit   (low_hit),
      .ok    (low_ok),
      .out   (batt_low)
   );

   // Rising-edge detector; the pulse itself is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_steer_d <= 1'b0;
         en_steer   <= 1'b0;
      end else begin
         en_steer_d <= en_steer_in;
         en_steer   <= en_steer_in & ~en_steer_d;
      end
   end

endmodule : alarm_qual

// File: tb/tb_alarm_qual.sv
// ---------------------------------------------------------------------------
// tb_alarm_qual
// Directed self-checking bench for alarm_qual. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edge that
// registered the sample.
// ---------------------------------------------------------------------------
module tb_alarm_qual;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld;
   logic [11:0] lft_spd, rght_spd, batt;
   logic        en_steer_in;
   logic        too_fast, batt_low, en_steer;

   int n_vec = 0;
   int n_err = 0;
   int pulses;

   always #5 clk = ~clk;

   alarm_qual dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vld         (vld),
      .lft_spd     (lft_spd),
      .rght_spd    (rght_spd),
      .batt        (batt),
      .en_steer_in (en_steer_in),
      .too_fast    (too_fast),
      .batt_low    (batt_low),
      .en_steer    (en_steer)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // One vld sample; returns on the next falling edge, when its effect is visible.
   task automatic apply(input int l, input int r, input int b);
      lft_spd  = 12'(l);
      rght_spd = 12'(r);
      batt     = 12'(b);
      vld      = 1'b1;
      @(negedge clk);
      vld      = 1'b0;
   endtask

   task automatic apply_n(input int n, input int l, input int r, input int b);
      for (int i = 0; i < n; i++) apply(l, r, b);
   endtask

   task automatic idle(input int n);
      vld = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   localparam int BOK = 'hA00;   // battery value in the clear band

   initial begin
      rst_n = 1'b0; vld = 1'b0; en_steer_in = 1'b0;
      lft_spd = '0; rght_spd = '0; batt = 12'(BOK);
      idle(3);
      rst_n = 1'b1;

      // Reset and idle
      idle(10);
      check("idle_too_fast", too_fast, 1'b0);
      check("idle_batt_low", batt_low, 1'b0);
      check("idle_en_steer", en_steer, 1'b0);

      // Overspeed: 3 hits then a neutral sample restarts the run
      apply_n(3, 1600, 0, BOK);
      check("fast_3hit", too_fast, 1'b0);
      apply(1500, 0, BOK);
      check("fast_neutral_break", too_fast, 1'b0);
      apply_n(3, 1600, 0, BOK);
      check("fast_restart_3", too_fast, 1'b0);
      apply(1600, 0, BOK);
      check("fast_set_4th", too_fast, 1'b1);

      // Clear with hysteresis
      apply_n(4, 1450, 1450, BOK);
      check("fast_neutral_hold", too_fast, 1'b1);
      apply_n(3, 1400, 1400, BOK);
      check("fast_clr_3", too_fast, 1'b1);
      apply(-1600, 0, BOK);
      check("fast_neg_break", too_fast, 1'b1);
      apply_n(4, -1600, 0, BOK);
      check("fast_neg_hold", too_fast, 1'b1);
      apply_n(3, 1400, 1400, BOK);
      check("fast_clr_restart_3", too_fast, 1'b1);
      apply(1400, 1400, BOK);
      check("fast_clr_4th", too_fast, 1'b0);

      // Exactly at threshold is not a hit
      apply_n(4, 1536, 1536, BOK);
      check("fast_at_thr", too_fast, 1'b0);

      // -2048 saturates to 2047, which is a hit
      apply_n(3, 0, -2048, BOK);
      check("fast_min_3", too_fast, 1'b0);
      apply(0, -2048, BOK);
      check("fast_min_set", too_fast, 1'b1);
      apply_n(4, 0, 0, BOK);
      check("fast_min_clr", too_fast, 1'b0);

      // Battery
      apply_n(4, 0, 0, 'h800);
      check("batt_at_thr", batt_low, 1'b0);
      apply_n(3, 0, 0, 'h7FF);
      check("batt_low_3", batt_low, 1'b0);
      apply(0, 0, 'h7FF);
      check("batt_low_set", batt_low, 1'b1);
      apply_n(4, 0, 0, 'h840);
      check("batt_neutral_hold", batt_low, 1'b1);
      apply_n(3, 0, 0, 'h841);
      check("batt_clr_3", batt_low, 1'b1);
      apply(0, 0, 'h841);
      check("batt_clr_4th", batt_low, 1'b0);
      check("batt_no_fast", too_fast, 1'b0);

      // Steer pulse: high 20, low 5, high 20 -> two pulses, each in the first cycle
      pulses = 0;
      for (int rep = 0; rep < 2; rep++) begin
         en_steer_in = 1'b1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("steer_r%0d_c%0d", rep, i), en_steer, (i == 0));
            if (en_steer) pulses++;
         end
         en_steer_in = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("steer_low_r%0d_c%0d", rep, i), en_steer, 1'b0);
         end
      end
      check("steer_two_pulses", (pulses == 2), 1'b1);

      // Simultaneous events
      apply_n(3, 1600, 0, 'h7FF);
      check("sim_pend_fast", too_fast, 1'b0);
      en_steer_in = 1'b1;
      apply(1600, 0, 'h7FF);
      check("sim_too_fast", too_fast, 1'b1);
      check("sim_batt_low", batt_low, 1'b1);
      check("sim_en_steer", en_steer, 1'b1);

      // Async reset clears immediately
      rst_n = 1'b0;
      #1;
      check("rst_too_fast", too_fast, 1'b0);
      check("rst_batt_low", batt_low, 1'b0);
      check("rst_en_steer", en_steer, 1'b0);
      en_steer_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in PEND_ON with cnt=2 discards the count
      apply_n(2, 1600, 0, BOK);
      rst_n = 1'b0;
      #1;
      check("rst_pend_out", too_fast, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_n(3, 1600, 0, BOK);
      check("rst_fresh_3", too_fast, 1'b0);
      apply(1600, 0, BOK);
      check("rst_fresh_4th", too_fast, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_alarm_qual
